// File: rtl/stop_watch_pkg.sv
// Shared types for the BCD stopwatch: digit type, digit limit and lap FSM encoding.
package stop_watch_pkg;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } lap_st_e;
endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit, 0..9, with synchronous clear and a carry out when it rolls from 9.
module bcd_digit_cnt
    import stop_watch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output bcd_t q_o,
    output logic carry_o
);
    bcd_t r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else if (clr_i)
            r_q <= '0;
        else if (inc_i)
            r_q <= (r_q == BCD_MAX) ? bcd_t'(0) : r_q + bcd_t'(1);
    end

    assign q_o     = r_q;
    assign carry_o = inc_i && (r_q == BCD_MAX);
endmodule

// File: rtl/stop_watch_bcd_n.sv
// NDIG-digit BCD stopwatch: prescaler, digit cascade, lap freeze, sticky overflow.
// Define STOP_WATCH_SAT_EN to saturate at all-9s instead of wrapping to zero.
module stop_watch_bcd_n
    import stop_watch_pkg::*;
#(
    parameter int NDIG   = 3,
    parameter int DVSR   = 5000000,
    parameter int DVSR_W = 23
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic                clr,
    input  logic                lap,
    output logic [4*NDIG-1:0]   disp_o,
    output logic [4*NDIG-1:0]   cnt_o,
    output logic                tick_o,
    output logic                lap_act_o,
    output logic                ovf_o
);
    localparam logic [DVSR_W-1:0] PRE_MAX = DVSR_W'(DVSR - 1);

    logic [DVSR_W-1:0]  r_pre;
    logic               r_tick;
    logic               r_ovf;
    lap_st_e            r_st;
    logic [4*NDIG-1:0]  r_lap;
    logic               r_lap_act;

    bcd_t [NDIG-1:0]    w_q;
    logic [NDIG-1:0]    w_inc;
    logic [NDIG-1:0]    w_carry;
    logic               w_tick;
    logic               w_ovf_set;

    assign w_tick = go && !clr && (r_pre == PRE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pre <= '0;
        else if (clr)
            r_pre <= '0;
        else if (go)
            r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + DVSR_W'(1);
    end

`ifdef STOP_WATCH_SAT_EN
    logic w_all9;
    always_comb begin
        w_all9 = 1'b1;
        for (int i = 0; i < NDIG; i++)
            if (w_q[i] != BCD_MAX) w_all9 = 1'b0;
    end
    // Block the whole cascade at all-9s so the digits hold.
    assign w_inc[0]  = w_tick && !w_all9;
    assign w_ovf_set = w_tick && w_all9;
`else
    assign w_inc[0]  = w_tick;
    assign w_ovf_set = w_carry[NDIG-1];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_dig
            if (gi > 0) begin : g_chain
                assign w_inc[gi] = w_carry[gi-1];
            end
            bcd_digit_cnt u_dig (
                .clk     (clk),
                .rst_n   (rst_n),
                .inc_i   (w_inc[gi]),
                .clr_i   (clr),
                .q_o     (w_q[gi]),
                .carry_o (w_carry[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (clr) begin
            r_tick <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_tick <= w_tick;
            if (w_ovf_set) r_ovf <= 1'b1;
        end
    end

    // Capture uses the pre-tick count since digits update on this same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st      <= LIVE;
            r_lap     <= '0;
            r_lap_act <= 1'b0;
        end else if (clr) begin
            r_st      <= LIVE;
            r_lap     <= '0;
            r_lap_act <= 1'b0;
        end else if (lap) begin
            case (r_st)
                LIVE: begin
                    r_lap     <= w_q;
                    r_st      <= FROZEN;
                    r_lap_act <= 1'b1;
                end
                FROZEN: begin
                    r_st      <= LIVE;
                    r_lap_act <= 1'b0;
                end
                default: begin
                    r_st      <= LIVE;
                    r_lap_act <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_o     = w_q;
    assign disp_o    = (r_st == FROZEN) ? r_lap : w_q;
    assign tick_o    = r_tick;
    assign lap_act_o = r_lap_act;
    assign ovf_o     = r_ovf;
endmodule

// File: tb/tb_stop_watch_bcd_n.sv
// Randomised and directed bench for stop_watch_bcd_n against an integer-count reference model.
module tb_stop_watch_bcd_n;
    localparam int NDIG = 3;
    localparam int DVSR = 4;
    localparam int MAXV = 999;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic go = 1'b0, clr = 1'b0, lap = 1'b0;
    logic [4*NDIG-1:0] disp_o, cnt_o;
    logic tick_o, lap_act_o, ovf_o;

    int n_chk = 0;
    int n_fail = 0;

    int m_pre, m_cnt, m_lap;
    bit m_frz, m_tick, m_ovf;

    stop_watch_bcd_n #(.NDIG(NDIG), .DVSR(DVSR), .DVSR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .clr(clr), .lap(lap),
        .disp_o(disp_o), .cnt_o(cnt_o), .tick_o(tick_o),
        .lap_act_o(lap_act_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    function automatic logic [4*NDIG-1:0] bcd(input int v);
        logic [4*NDIG-1:0] r;
        int p;
        p = v;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(p % 10);
            p = p / 10;
        end
        return r;
    endfunction

    function automatic logic [4*NDIG-1:0] e_disp();
        return m_frz ? bcd(m_lap) : bcd(m_cnt);
    endfunction

    task automatic model_reset();
        m_pre = 0; m_cnt = 0; m_lap = 0;
        m_frz = 0; m_tick = 0; m_ovf = 0;
    endtask

    // Drive one cycle of inputs, clock it, advance the reference model, sample 1ns later.
    task automatic step(input bit g, input bit c, input bit l);
        bit t;
        go = g; clr = c; lap = l;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            t = g && (m_pre == DVSR - 1);
            if (l) begin
                if (!m_frz) begin m_lap = m_cnt; m_frz = 1; end
                else m_frz = 0;
            end
            if (g) m_pre = (m_pre + 1) % DVSR;
            m_tick = t;
            if (t) begin
                if (m_cnt == MAXV) begin
                    m_ovf = 1;
`ifdef STOP_WATCH_SAT_EN
                    m_cnt = MAXV;
`else
                    m_cnt = 0;
`endif
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; go = 1'b1;
        model_reset();
        #2;
        n_chk++;
        if (disp_o !== '0 || cnt_o !== '0 || tick_o !== 1'b0 || lap_act_o !== 1'b0 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset disp=%h cnt=%h tick=%b lap=%b ovf=%b want all zero", disp_o, cnt_o, tick_o, lap_act_o, ovf_o);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_run();
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0);
            n_chk++;
            if (disp_o !== e_disp() || cnt_o !== bcd(m_cnt) || tick_o !== m_tick || lap_act_o !== m_frz || ovf_o !== m_ovf) begin
                n_fail++;
                $display("FAIL run cyc=%0d disp=%h cnt=%h tick=%b want disp=%h cnt=%h tick=%b", i, disp_o, cnt_o, tick_o, e_disp(), bcd(m_cnt), m_tick);
            end
        end
        n_chk++;
        if (cnt_o !== 12'h010 || disp_o !== 12'h010) begin
            n_fail++;
            $display("FAIL run_40 cnt=%h disp=%h want 010", cnt_o, disp_o);
        end
    endtask

    task automatic test_wrap();
        int guard;
        guard = 0;
        while (!(m_cnt == MAXV && m_tick) && guard < 5000) begin
            step(1, 0, 0);
            guard++;
            n_chk++;
            if (cnt_o !== bcd(m_cnt) || tick_o !== m_tick || ovf_o !== m_ovf || disp_o !== e_disp()) begin
                n_fail++;
                $display("FAIL wrap_run cnt=%h tick=%b ovf=%b want cnt=%h tick=%b ovf=%b", cnt_o, tick_o, ovf_o, bcd(m_cnt), m_tick, m_ovf);
            end
        end
        n_chk++;
        if (guard >= 5000) begin n_fail++; $display("FAIL wrap_timeout cnt=%h never reached 999", cnt_o); end
        for (int i = 0; i < DVSR; i++) step(1, 0, 0);
        n_chk++;
`ifdef STOP_WATCH_SAT_EN
        if (cnt_o !== 12'h999 || ovf_o !== 1'b1 || tick_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_edge cnt=%h ovf=%b tick=%b want 999 1 1", cnt_o, ovf_o, tick_o);
        end
`else
        if (cnt_o !== 12'h000 || ovf_o !== 1'b1 || tick_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_edge cnt=%h ovf=%b tick=%b want 000 1 1", cnt_o, ovf_o, tick_o);
        end
`endif
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0);
            n_chk++;
            if (ovf_o !== 1'b1 || cnt_o !== bcd(m_cnt)) begin
                n_fail++;
                $display("FAIL ovf_sticky ovf=%b cnt=%h want 1 %h", ovf_o, cnt_o, bcd(m_cnt));
            end
        end
        step(1, 1, 0);
        n_chk++;
        if (ovf_o !== 1'b0 || cnt_o !== '0 || tick_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr ovf=%b cnt=%h tick=%b want 0 000 0", ovf_o, cnt_o, tick_o);
        end
    endtask

    task automatic test_pause();
        logic [4*NDIG-1:0] held;
        int n;
        step(1, 0, 0);
        while (m_pre != 2) step(1, 0, 0);
        held = cnt_o;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0);
            n_chk++;
            if (cnt_o !== held || tick_o !== 1'b0 || cnt_o !== bcd(m_cnt)) begin
                n_fail++;
                $display("FAIL pause_hold cnt=%h tick=%b want %h 0", cnt_o, tick_o, held);
            end
        end
        n = 0;
        do begin
            step(1, 0, 0);
            n++;
        end while (tick_o !== 1'b1 && n < 8);
        n_chk++;
        if (n !== 2 || cnt_o !== bcd(m_cnt)) begin
            n_fail++;
            $display("FAIL pause_resume cycles=%0d cnt=%h want 2 %h", n, cnt_o, bcd(m_cnt));
        end
    endtask

    task automatic test_lap();
        step(1, 1, 0);
        while (m_cnt != 23) step(1, 0, 0);
        step(1, 0, 1);
        n_chk++;
        if (disp_o !== 12'h023 || lap_act_o !== 1'b1 || cnt_o !== 12'h023) begin
            n_fail++;
            $display("FAIL lap_capture disp=%h act=%b cnt=%h want 023 1 023", disp_o, lap_act_o, cnt_o);
        end
        while (m_cnt != 27) begin
            step(1, 0, 0);
            n_chk++;
            if (disp_o !== 12'h023 || cnt_o !== bcd(m_cnt) || lap_act_o !== 1'b1) begin
                n_fail++;
                $display("FAIL lap_frozen disp=%h cnt=%h want 023 %h", disp_o, cnt_o, bcd(m_cnt));
            end
        end
        step(1, 0, 1);
        n_chk++;
        if (disp_o !== 12'h027 || lap_act_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lap_release disp=%h act=%b want 027 0", disp_o, lap_act_o);
        end
        while (!(m_cnt == 30 && m_pre == DVSR - 1)) step(1, 0, 0);
        step(1, 0, 1);
        n_chk++;
        if (disp_o !== 12'h030 || cnt_o !== 12'h031 || tick_o !== 1'b1 || lap_act_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_with_tick disp=%h cnt=%h tick=%b want 030 031 1", disp_o, cnt_o, tick_o);
        end
        step(1, 0, 1);
    endtask

    task automatic test_clr();
        while (!(m_cnt == 456 && m_pre == 2)) step(1, 0, 0);
        step(1, 0, 1);
        step(1, 1, 1);
        n_chk++;
        if (disp_o !== '0 || cnt_o !== '0 || tick_o !== 1'b0 || lap_act_o !== 1'b0 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_prio disp=%h cnt=%h tick=%b act=%b ovf=%b want all zero", disp_o, cnt_o, tick_o, lap_act_o, ovf_o);
        end
        for (int i = 0; i < DVSR; i++) begin
            step(1, 0, 0);
            n_chk++;
            if (tick_o !== (i == DVSR - 1) || cnt_o !== bcd(m_cnt)) begin
                n_fail++;
                $display("FAIL clr_restart cyc=%0d tick=%b cnt=%h want %b %h", i, tick_o, cnt_o, (i == DVSR - 1), bcd(m_cnt));
            end
        end
    endtask

    task automatic test_async_reset();
        while (m_cnt != 789) step(1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if (disp_o !== '0 || cnt_o !== '0 || tick_o !== 1'b0 || lap_act_o !== 1'b0 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset disp=%h cnt=%h tick=%b act=%b ovf=%b want zero", disp_o, cnt_o, tick_o, lap_act_o, ovf_o);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0);
            n_chk++;
            if (cnt_o !== bcd(m_cnt) || tick_o !== m_tick) begin
                n_fail++;
                $display("FAIL after_reset cnt=%h tick=%b want %h %b", cnt_o, tick_o, bcd(m_cnt), m_tick);
            end
        end
    endtask

    task automatic test_random();
        bit g, c, l;
        for (int i = 0; i < 600; i++) begin
            g = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 6);
            step(g, c, l);
            n_chk++;
            if (disp_o !== e_disp() || cnt_o !== bcd(m_cnt) || tick_o !== m_tick || lap_act_o !== m_frz || ovf_o !== m_ovf) begin
                n_fail++;
                $display("FAIL random cyc=%0d disp=%h cnt=%h tick=%b act=%b ovf=%b want %h %h %b %b %b",
                         i, disp_o, cnt_o, tick_o, lap_act_o, ovf_o, e_disp(), bcd(m_cnt), m_tick, m_frz, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_wrap();
        test_pause();
        test_lap();
        test_clr();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
